// File: rtl/control_multiciclo.sv
// rtl/control_multiciclo.sv - multi-cycle RV32I control FSM with memory handshake timeout
module control_multiciclo #(
    parameter int ESPERA_MAX   = 255,
    parameter int ANCHO_CUENTA = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       cond,
    input  logic       mem_listo,
    output logic [1:0] modo,
    output logic       mem_valido,
    output logic       mem_escribe,
    output logic       mem_dir_sel,
    output logic       escribe_ir,
    output logic       escribe_pc,
    output logic [1:0] sel_pc,
    output logic       escribe_reg,
    output logic [1:0] sel_wb,
    output logic [1:0] sel_a,
    output logic       sel_b,
    output logic       instr_fin,
    output logic       error
);

    localparam logic [3:0] INICIO  = 4'd0;
    localparam logic [3:0] FETCH   = 4'd1;
    localparam logic [3:0] DECODE  = 4'd2;
    localparam logic [3:0] EXEC_R  = 4'd3;
    localparam logic [3:0] EXEC_I  = 4'd4;
    localparam logic [3:0] ALU_WB  = 4'd5;
    localparam logic [3:0] ADDR    = 4'd6;
    localparam logic [3:0] MEM_LEE = 4'd7;
    localparam logic [3:0] MEM_WB  = 4'd8;
    localparam logic [3:0] MEM_ESC = 4'd9;
    localparam logic [3:0] BRANCH  = 4'd10;
    localparam logic [3:0] JAL     = 4'd11;
    localparam logic [3:0] JALR    = 4'd12;
    localparam logic [3:0] LUI     = 4'd13;
    localparam logic [3:0] AUIPC   = 4'd14;
    localparam logic [3:0] ERROR   = 4'd15;

    localparam logic [ANCHO_CUENTA-1:0] CUENTA_ULTIMA = ANCHO_CUENTA'(ESPERA_MAX - 1);
    localparam logic [ANCHO_CUENTA-1:0] UNO           = ANCHO_CUENTA'(1);

    logic [3:0]              estado;
    logic [3:0]              siguiente;
    logic [ANCHO_CUENTA-1:0] cuenta;
    logic                    espera;
    logic                    agotado;

    assign espera  = (estado == FETCH || estado == MEM_LEE || estado == MEM_ESC) && !mem_listo;
    // This cycle is the ESPERA_MAX-th consecutive one without mem_listo.
    assign agotado = espera && (cuenta == CUENTA_ULTIMA);

    always_comb begin
        siguiente = estado;
        case (estado)
            INICIO:  siguiente = FETCH;
            FETCH:   siguiente = mem_listo ? DECODE : (agotado ? ERROR : FETCH);
            DECODE: begin
                case (opcode)
                    7'd51:        siguiente = EXEC_R;
                    7'd19:        siguiente = EXEC_I;
                    7'd3, 7'd35:  siguiente = ADDR;
                    7'd99:        siguiente = BRANCH;
                    7'd111:       siguiente = JAL;
                    7'd103:       siguiente = JALR;
                    7'd55:        siguiente = LUI;
                    7'd23:        siguiente = AUIPC;
                    default:      siguiente = ERROR;
                endcase
            end
            EXEC_R, EXEC_I: siguiente = ALU_WB;
            ADDR:    siguiente = (opcode == 7'd3) ? MEM_LEE : ((opcode == 7'd35) ? MEM_ESC : ERROR);
            MEM_LEE: siguiente = mem_listo ? MEM_WB : (agotado ? ERROR : MEM_LEE);
            MEM_ESC: siguiente = mem_listo ? FETCH : (agotado ? ERROR : MEM_ESC);
            ALU_WB, MEM_WB, BRANCH, JAL, JALR, LUI, AUIPC: siguiente = FETCH;
            ERROR:   siguiente = ERROR;
            default: siguiente = ERROR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado <= INICIO;
            cuenta <= '0;
        end else begin
            estado <= siguiente;
            if (siguiente != estado)
                cuenta <= '0;
            else if (espera)
                cuenta <= cuenta + UNO;
        end
    end

    always_comb begin
        modo        = 2'b00;
        mem_valido  = 1'b0;
        mem_escribe = 1'b0;
        mem_dir_sel = 1'b0;
        escribe_ir  = 1'b0;
        escribe_pc  = 1'b0;
        sel_pc      = 2'b00;
        escribe_reg = 1'b0;
        sel_wb      = 2'b00;
        sel_a       = 2'b00;
        sel_b       = 1'b0;
        instr_fin   = 1'b0;
        error       = 1'b0;
        case (estado)
            FETCH: begin
                mem_valido = 1'b1;
                escribe_ir = mem_listo && !reset;
                escribe_pc = mem_listo && !reset;
            end
            DECODE: begin
                sel_a = 2'b01;
                sel_b = 1'b1;
            end
            EXEC_R: modo = 2'b10;
            EXEC_I: begin
                modo  = 2'b01;
                sel_b = 1'b1;
            end
            ALU_WB, AUIPC: begin
                escribe_reg = !reset;
                instr_fin   = 1'b1;
            end
            ADDR: sel_b = 1'b1;
            MEM_LEE: begin
                mem_valido  = 1'b1;
                mem_dir_sel = 1'b1;
            end
            MEM_WB: begin
                escribe_reg = !reset;
                sel_wb      = 2'b01;
                instr_fin   = 1'b1;
            end
            MEM_ESC: begin
                mem_valido  = 1'b1;
                mem_escribe = 1'b1;
                mem_dir_sel = 1'b1;
                instr_fin   = mem_listo;
            end
            BRANCH: begin
                modo       = 2'b11;
                sel_pc     = 2'b01;
                escribe_pc = (cond ^ funct3[0]) && !reset;
                instr_fin  = 1'b1;
            end
            JAL: begin
                escribe_reg = !reset;
                sel_wb      = 2'b10;
                escribe_pc  = !reset;
                sel_pc      = 2'b01;
                instr_fin   = 1'b1;
            end
            JALR: begin
                sel_b       = 1'b1;
                escribe_pc  = !reset;
                sel_pc      = 2'b10;
                escribe_reg = !reset;
                sel_wb      = 2'b10;
                instr_fin   = 1'b1;
            end
            LUI: begin
                escribe_reg = !reset;
                sel_wb      = 2'b11;
                instr_fin   = 1'b1;
            end
            ERROR: error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_multiciclo.sv
// tb/tb_control_multiciclo.sv - scoreboard bench for control_multiciclo
module tb_control_multiciclo;

    logic       clk;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       cond;
    logic       mem_listo;
    logic [1:0] modo;
    logic       mem_valido, mem_escribe, mem_dir_sel;
    logic       escribe_ir, escribe_pc;
    logic [1:0] sel_pc;
    logic       escribe_reg;
    logic [1:0] sel_wb, sel_a;
    logic       sel_b, instr_fin, error;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        l;
        logic        c;
        logic [16:0] e;
    } paso_t;

    logic [16:0] sb[$];
    logic [16:0] esperado;
    logic [16:0] obs;

    control_multiciclo #(.ESPERA_MAX(4), .ANCHO_CUENTA(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .cond(cond),
        .mem_listo(mem_listo), .modo(modo), .mem_valido(mem_valido),
        .mem_escribe(mem_escribe), .mem_dir_sel(mem_dir_sel), .escribe_ir(escribe_ir),
        .escribe_pc(escribe_pc), .sel_pc(sel_pc), .escribe_reg(escribe_reg),
        .sel_wb(sel_wb), .sel_a(sel_a), .sel_b(sel_b), .instr_fin(instr_fin), .error(error)
    );

    assign obs = {modo, mem_valido, mem_escribe, mem_dir_sel, escribe_ir, escribe_pc,
                  sel_pc, escribe_reg, sel_wb, sel_a, sel_b, instr_fin, error};

    always #5 clk = ~clk;

    function automatic logic [16:0] v(input logic [1:0] m, input logic mv, input logic me,
                                      input logic md, input logic eir, input logic epc,
                                      input logic [1:0] spc, input logic ereg, input logic [1:0] swb,
                                      input logic [1:0] sa, input logic sbb, input logic fin,
                                      input logic err);
        return {m, mv, me, md, eir, epc, spc, ereg, swb, sa, sbb, fin, err};
    endfunction

    function automatic logic [16:0] x_fetch(input logic l);
        return v(2'b00, 1, 0, 0, l, l, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] x_dec();
        return v(2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b01, 1, 0, 0);
    endfunction
    function automatic logic [16:0] x_exr();
        return v(2'b10, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] x_exi();
        return v(2'b01, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    endfunction
    function automatic logic [16:0] x_wb(input logic [1:0] swb);
        return v(2'b00, 0, 0, 0, 0, 0, 2'b00, 1, swb, 2'b00, 0, 1, 0);
    endfunction
    function automatic logic [16:0] x_addr();
        return v(2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 1, 0, 0);
    endfunction
    function automatic logic [16:0] x_lee();
        return v(2'b00, 1, 0, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 0);
    endfunction
    function automatic logic [16:0] x_esc(input logic l);
        return v(2'b00, 1, 1, 1, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, l, 0);
    endfunction
    function automatic logic [16:0] x_br(input logic t);
        return v(2'b11, 0, 0, 0, 0, t, 2'b01, 0, 2'b00, 2'b00, 0, 1, 0);
    endfunction
    function automatic logic [16:0] x_jal();
        return v(2'b00, 0, 0, 0, 0, 1, 2'b01, 1, 2'b10, 2'b00, 0, 1, 0);
    endfunction
    function automatic logic [16:0] x_jalr();
        return v(2'b00, 0, 0, 0, 0, 1, 2'b10, 1, 2'b10, 2'b00, 1, 1, 0);
    endfunction
    function automatic logic [16:0] x_err();
        return v(2'b00, 0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 2'b00, 0, 0, 1);
    endfunction

    function automatic paso_t p(input logic l, input logic c, input logic [16:0] e);
        paso_t r;
        r.l = l; r.c = c; r.e = e;
        return r;
    endfunction

    task automatic test_reset(input string nombre);
        reset = 1;
        mem_listo = 1;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL %s_asserted: got %b want %b", nombre, obs, 17'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if (obs !== 17'd0) begin
            errors++;
            $display("FAIL %s_inicio: got %b want %b", nombre, obs, 17'd0);
        end
    endtask

    task automatic test_add();
        paso_t s[$];
        opcode = 7'd51; funct3 = 3'd0;
        s.push_back(p(1, 0, x_fetch(1)));
        s.push_back(p(1, 0, x_dec()));
        s.push_back(p(1, 0, x_exr()));
        s.push_back(p(1, 0, x_wb(2'b00)));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL add step %0d: got %b want %b", i, obs, esperado);
            end
        end
    endtask

    task automatic test_load_slow();
        paso_t s[$];
        opcode = 7'd3; funct3 = 3'd2;
        s.push_back(p(1, 0, x_fetch(1)));
        s.push_back(p(1, 0, x_dec()));
        s.push_back(p(1, 0, x_addr()));
        s.push_back(p(0, 0, x_lee()));
        s.push_back(p(0, 0, x_lee()));
        s.push_back(p(0, 0, x_lee()));
        s.push_back(p(1, 0, x_lee()));
        s.push_back(p(1, 0, x_wb(2'b01)));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL load_slow step %0d: got %b want %b", i, obs, esperado);
            end
        end
    endtask

    task automatic test_back_to_back();
        paso_t s[$];
        opcode = 7'd35; funct3 = 3'd2;
        s.push_back(p(0, 0, x_fetch(0)));
        s.push_back(p(0, 0, x_fetch(0)));
        s.push_back(p(0, 0, x_fetch(0)));
        s.push_back(p(1, 0, x_fetch(1)));
        s.push_back(p(1, 0, x_dec()));
        s.push_back(p(1, 0, x_addr()));
        s.push_back(p(1, 0, x_esc(1)));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b want %b", i, obs, esperado);
            end
        end
    endtask

    task automatic test_branch();
        logic [1:0] casos [4] = '{2'b01, 2'b00, 2'b11, 2'b10};
        for (int k = 0; k < 4; k++) begin
            paso_t s[$];
            logic tomado;
            opcode = 7'd99; funct3 = {2'b00, casos[k][1]};
            tomado = casos[k][0] ^ casos[k][1];
            s.push_back(p(1, casos[k][0], x_fetch(1)));
            s.push_back(p(1, casos[k][0], x_dec()));
            s.push_back(p(1, casos[k][0], x_br(tomado)));
            foreach (s[i]) begin
                @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
                #1; esperado = sb.pop_front(); checks++;
                if (obs !== esperado) begin
                    errors++;
                    $display("FAIL branch case %0d step %0d: got %b want %b", k, i, obs, esperado);
                end
            end
        end
    endtask

    task automatic test_jumps_upper();
        logic [6:0]  ops  [5] = '{7'd111, 7'd103, 7'd55, 7'd23, 7'd19};
        for (int k = 0; k < 5; k++) begin
            paso_t s[$];
            opcode = ops[k]; funct3 = 3'd0;
            s.push_back(p(1, 0, x_fetch(1)));
            s.push_back(p(1, 0, x_dec()));
            case (k)
                0: s.push_back(p(1, 0, x_jal()));
                1: s.push_back(p(1, 0, x_jalr()));
                2: s.push_back(p(1, 0, x_wb(2'b11)));
                3: s.push_back(p(1, 0, x_wb(2'b00)));
                default: begin
                    s.push_back(p(1, 0, x_exi()));
                    s.push_back(p(1, 0, x_wb(2'b00)));
                end
            endcase
            foreach (s[i]) begin
                @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
                #1; esperado = sb.pop_front(); checks++;
                if (obs !== esperado) begin
                    errors++;
                    $display("FAIL jump_upper op %0d step %0d: got %b want %b", ops[k], i, obs, esperado);
                end
            end
        end
    endtask

    task automatic test_illegal();
        paso_t s[$];
        opcode = 7'h7f; funct3 = 3'd0;
        s.push_back(p(1, 0, x_fetch(1)));
        s.push_back(p(1, 0, x_dec()));
        for (int n = 0; n < 20; n++) s.push_back(p(n[0], 0, x_err()));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL illegal step %0d: got %b want %b", i, obs, esperado);
            end
        end
    endtask

    task automatic test_timeout();
        paso_t s[$];
        opcode = 7'd51; funct3 = 3'd0;
        for (int n = 0; n < 4; n++) s.push_back(p(0, 0, x_fetch(0)));
        for (int n = 0; n < 3; n++) s.push_back(p(1, 0, x_err()));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL timeout step %0d: got %b want %b", i, obs, esperado);
            end
        end
    endtask

    task automatic test_reset_mid_esc();
        paso_t s[$];
        opcode = 7'd35; funct3 = 3'd0;
        s.push_back(p(1, 0, x_fetch(1)));
        s.push_back(p(1, 0, x_dec()));
        s.push_back(p(1, 0, x_addr()));
        s.push_back(p(0, 0, x_esc(0)));
        s.push_back(p(0, 0, x_esc(0)));
        foreach (s[i]) begin
            @(negedge clk); mem_listo = s[i].l; cond = s[i].c; sb.push_back(s[i].e);
            #1; esperado = sb.pop_front(); checks++;
            if (obs !== esperado) begin
                errors++;
                $display("FAIL mid_esc step %0d: got %b want %b", i, obs, esperado);
            end
        end
        #1;
        test_reset("reset_mid_esc");
        @(negedge clk); mem_listo = 1; sb.push_back(x_fetch(1));
        #1; esperado = sb.pop_front(); checks++;
        if (obs !== esperado) begin
            errors++;
            $display("FAIL fetch_after_reset: got %b want %b", obs, esperado);
        end
    endtask

    initial begin
        clk = 0; reset = 1; opcode = '0; funct3 = '0; cond = 0; mem_listo = 0;
        test_reset("reset");
        test_add();
        test_load_slow();
        test_back_to_back();
        test_branch();
        test_jumps_upper();
        test_illegal();
        test_reset("reset_after_illegal");
        test_timeout();
        test_reset("reset_after_timeout");
        test_reset_mid_esc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
